// File: rtl/seg7_pkg.sv
// seg7_pkg: definitions shared by the 7-segment display driver.
//   - seg7_state_t : conversion FSM states (IDLE, CONV, DONE)
//   - SEG_0..SEG_9 : segment patterns {g,f,e,d,c,b,a}, active-high
//   - SEG_BLANK    : all segments off
//   - BLANK_CODE   : digit code that decodes to a blank digit
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } seg7_state_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Number of double-dabble iterations for an 8-bit input.
  localparam int unsigned CONV_ITERS = 8;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational digit-code to segment decoder.
// Ports:
//   code - 4-bit digit code; 0..9 are digits, anything else is blank
//   seg  - segments {g,f,e,d,c,b,a}, active-high
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_seg7_driver.sv
// display_seg7_driver: converts the displayed 8-bit result to BCD with a
// sequential double-dabble engine and drives a multiplexed 4-digit
// common-cathode 7-segment panel. Digit 3 (leftmost) shows the result
// index, digits 2..0 show the decimal value.
//
// Build option: SEG7_LZ_BLANK_EN enables leading-zero blanking of the
// hundreds and tens digits.
//
// Parameters:
//   SCAN_DIV       - clock cycles each digit stays enabled (2..65535)
// Ports:
//   clk            - system clock
//   reset          - synchronous, active-high
//   run_display    - controller is in its display state
//   display_result - unsigned value to show
//   state_display  - index of that value
//   seg_o          - segments {g,f,e,d,c,b,a}, active-high, registered
//   an_o           - one-hot digit enable, bit 3 leftmost, registered
//   busy_o         - conversion in progress
//   valid_o        - at least one conversion completed since reset
module display_seg7_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 16
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic       run_display,
  input  logic [7:0] display_result,
  input  logic [2:0] state_display,
  output logic [6:0] seg_o,
  output logic [3:0] an_o,
  output logic       busy_o,
  output logic       valid_o
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

  seg7_state_t state_reg, state_next;
  logic [19:0] shift_reg, shift_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [7:0]  cap_val_reg, cap_val_next;
  logic [2:0]  cap_idx_reg, cap_idx_next;
  logic [3:0]  hund_reg, hund_next;
  logic [3:0]  tens_reg, tens_next;
  logic [3:0]  ones_reg, ones_next;
  logic [3:0]  idx_reg, idx_next;
  logic        valid_reg, valid_next;
  logic [15:0] div_reg;
  logic [1:0]  ptr_reg;
  logic [3:0]  an_reg;
  logic [6:0]  seg_reg;

  // Add-3 correction applied to each BCD nibble before every shift.
  logic [11:0] bcd_adj;
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      logic [3:0] nib;
      assign nib = shift_reg[8 + gi*4 +: 4];
      assign bcd_adj[gi*4 +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  endgenerate

  logic new_pair;
  assign new_pair = !valid_reg ||
                    ({display_result, state_display} != {cap_val_reg, cap_idx_reg});

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    cnt_next     = cnt_reg;
    cap_val_next = cap_val_reg;
    cap_idx_next = cap_idx_reg;
    hund_next    = hund_reg;
    tens_next    = tens_reg;
    ones_next    = ones_reg;
    idx_next     = idx_reg;
    valid_next   = valid_reg;
    case (state_reg)
      ST_IDLE: begin
        if (run_display && new_pair) begin
          shift_next   = {12'd0, display_result};
          cap_val_next = display_result;
          cap_idx_next = state_display;
          cnt_next     = 4'd0;
          state_next   = ST_CONV;
        end
      end
      ST_CONV: begin
        shift_next = {bcd_adj[10:0], shift_reg[7:0], 1'b0};
        cnt_next   = cnt_reg + 4'd1;
        if (cnt_reg == 4'(CONV_ITERS - 1)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        hund_next  = shift_reg[19:16];
        tens_next  = shift_reg[15:12];
        ones_next  = shift_reg[11:8];
        idx_next   = {1'b0, cap_idx_reg};
        valid_next = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      cnt_reg     <= '0;
      cap_val_reg <= '0;
      cap_idx_reg <= '0;
      hund_reg    <= '0;
      tens_reg    <= '0;
      ones_reg    <= '0;
      idx_reg     <= '0;
      valid_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      cnt_reg     <= cnt_next;
      cap_val_reg <= cap_val_next;
      cap_idx_reg <= cap_idx_next;
      hund_reg    <= hund_next;
      tens_reg    <= tens_next;
      ones_reg    <= ones_next;
      idx_reg     <= idx_next;
      valid_reg   <= valid_next;
    end
  end

  // Digit codes after optional leading-zero blanking.
  logic [3:0] hund_code, tens_code;
`ifdef SEG7_LZ_BLANK_EN
  assign hund_code = (hund_reg == 4'd0) ? BLANK_CODE : hund_reg;
  assign tens_code = (hund_reg == 4'd0 && tens_reg == 4'd0) ? BLANK_CODE : tens_reg;
`else
  assign hund_code = hund_reg;
  assign tens_code = tens_reg;
`endif

  logic [3:0] digit_code;
  always_comb begin
    digit_code = ones_reg;
    case (ptr_reg)
      2'd3:    digit_code = idx_reg;
      2'd2:    digit_code = hund_code;
      2'd1:    digit_code = tens_code;
      default: digit_code = ones_reg;
    endcase
  end

  logic [6:0] seg_dec;
  seg7_decode u_decode (
    .code (digit_code),
    .seg  (seg_dec)
  );

  logic show;
  assign show = run_display && valid_reg;

  // Scan divider and pointer; the pointer walks 3,2,1,0 by 2-bit wraparound.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg <= '0;
      ptr_reg <= 2'd3;
      an_reg  <= '0;
      seg_reg <= '0;
    end else begin
      if (div_reg == DIV_LAST) begin
        div_reg <= '0;
        ptr_reg <= ptr_reg - 2'd1;
      end else begin
        div_reg <= div_reg + 16'd1;
      end
      an_reg  <= show ? (4'b0001 << ptr_reg) : 4'b0000;
      seg_reg <= show ? seg_dec : SEG_BLANK;
    end
  end

  assign seg_o   = seg_reg;
  assign an_o    = an_reg;
  assign busy_o  = (state_reg != ST_IDLE);
  assign valid_o = valid_reg;

endmodule

// File: tb/tb_display_seg7_driver.sv
// Bench for display_seg7_driver: directed and randomized conversions, checked
// against a decimal-arithmetic reference of what each panel digit must show.
module tb_display_seg7_driver;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run_display = 1'b0;
  logic [7:0] display_result = 8'd0;
  logic [2:0] state_display = 3'd0;
  logic [6:0] seg_o;
  logic [3:0] an_o;
  logic       busy_o;
  logic       valid_o;

  int vectors = 0;
  int fails   = 0;

  display_seg7_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk            (clk),
    .reset          (reset),
    .run_display    (run_display),
    .display_result (display_result),
    .state_display  (state_display),
    .seg_o          (seg_o),
    .an_o           (an_o),
    .busy_o         (busy_o),
    .valid_o        (valid_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Segment pattern of a decimal digit; 15 is blank.
  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] tab [10];
    tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    if (d >= 0 && d <= 9) return tab[d];
    return 7'h00;
  endfunction

  // What panel position pos (3 = leftmost) must show for value v at index ix.
  function automatic logic [6:0] ref_seg(input int pos, input int v, input int ix);
    int h, t, o, d;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
`ifdef SEG7_LZ_BLANK_EN
    if (h == 0) begin
      if (t == 0) t = 15;
      h = 15;
    end
`endif
    case (pos)
      3: d = ix;
      2: d = h;
      1: d = t;
      default: d = o;
    endcase
    return seg_of(d);
  endfunction

  function automatic int pos_of(input logic [3:0] an);
    if (an[3]) return 3;
    if (an[2]) return 2;
    if (an[1]) return 1;
    return 0;
  endfunction

  int last_v = -1;
  int last_i = -1;

  // Watch the panel for n cycles: one digit lit, correct pattern, correct
  // scan order and dwell time.
  task automatic scan_check(input int v, input int ix, input int n);
    logic [3:0] prev;
    logic [3:0] rot;
    int len;
    bit full;
    full = 0;
    len  = 0;
    prev = 4'b0000;
    for (int c = 0; c < n; c++) begin
      tick();
      check("an_onehot", $countones(an_o), 1);
      check($sformatf("seg v=%0d ix=%0d an=%b", v, ix, an_o), seg_o, ref_seg(pos_of(an_o), v, ix));
      if (c == 0) begin
        prev = an_o;
        len  = 1;
      end else if (an_o == prev) begin
        len++;
      end else begin
        if (full) check("dwell", len, SCAN_DIV);
        rot = (prev == 4'b0001) ? 4'b1000 : (prev >> 1);
        check("scan_order", an_o, rot);
        full = 1;
        len  = 1;
        prev = an_o;
      end
    end
  endtask

  // Present a new pair, follow one conversion, then watch the panel.
  task automatic conv_and_check(input int v, input int ix);
    int waited;
    int busy_cnt;
    run_display    = 1'b1;
    display_result = 8'(v);
    state_display  = 3'(ix);
    waited = 0;
    tick();
    while (!busy_o && waited < 5) begin
      tick();
      waited++;
    end
    check("busy_start", busy_o, 1);
    busy_cnt = 0;
    while (busy_o && busy_cnt < 30) begin
      busy_cnt++;
      tick();
    end
    check($sformatf("busy_len v=%0d", v), busy_cnt, 9);
    check("valid_after_conv", valid_o, 1);
    last_v = v;
    last_i = ix;
    scan_check(v, ix, 6 * SCAN_DIV);
  endtask

  initial begin
    int v, ix, convs, k;
    logic pb;

    // Reset held two cycles.
    reset = 1'b1;
    tick();
    tick();
    check("rst_seg", seg_o, 0);
    check("rst_an", an_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_valid", valid_o, 0);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("idle_an", an_o, 0);
      check("idle_busy", busy_o, 0);
    end

    // Directed value 123 at index 2.
    conv_and_check(123, 2);

    // Sweep 1..12, one step every 32 cycles; each value converts once.
    convs = 0;
    pb = busy_o;
    for (int i = 1; i <= 12; i++) begin
      display_result = 8'(i);
      state_display  = 3'(i % 8);
      for (int c = 0; c < 32; c++) begin
        tick();
        if (busy_o && !pb) convs++;
        pb = busy_o;
      end
    end
    check("sweep_convs", convs, 12);
    last_v = 12;
    last_i = 4;
    scan_check(12, 4, 6 * SCAN_DIV);

    // Extremes.
    conv_and_check(255, 7);
    conv_and_check(0, 0);

    // Randomized values and indices.
    for (int r = 0; r < 8; r++) begin
      v  = int'($urandom_range(0, 255));
      ix = int'($urandom_range(0, 7));
      if (v == last_v && ix == last_i) v = v ^ 1;
      conv_and_check(v, ix);
    end

    // Input change during conversion: first result is the old value,
    // the new one is captured right after.
    display_result = 8'd200;
    state_display  = 3'd5;
    k = 0;
    tick();
    while (!busy_o && k < 5) begin
      tick();
      k++;
    end
    check("chg_busy_start", busy_o, 1);
    for (k = 1; k <= 19; k++) begin
      tick();
      if (k == 3) display_result = 8'd47;
      if (k == 9) begin
        check("chg_busy_n9", busy_o, 0);
        check("chg_valid_n9", valid_o, 1);
      end
      if (k == 10) check("chg_recapture_n10", busy_o, 1);
      if (k >= 10) check($sformatf("chg_old_seg k=%0d", k), seg_o, ref_seg(pos_of(an_o), 200, 5));
      if (k == 18) check("chg_busy_n18", busy_o, 1);
      if (k == 19) check("chg_busy_n19", busy_o, 0);
    end
    last_v = 47;
    last_i = 5;
    scan_check(47, 5, 6 * SCAN_DIV);

    // Reset in the middle of a conversion.
    display_result = 8'd99;
    state_display  = 3'd3;
    k = 0;
    tick();
    while (!busy_o && k < 5) begin
      tick();
      k++;
    end
    check("mrst_busy_start", busy_o, 1);
    for (k = 1; k <= 4; k++) tick();
    reset = 1'b1;
    tick();
    check("mrst_busy", busy_o, 0);
    check("mrst_valid", valid_o, 0);
    check("mrst_an", an_o, 0);
    check("mrst_seg", seg_o, 0);
    reset = 1'b0;
    conv_and_check(99, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
